// File: rtl/alpha_blend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alpha_blend_sequencer
//  Purpose  : Sequences a shared combinational vector ALU to execute either a
//             single vector operation (one ALU cycle) or a per-lane alpha
//             composite out = (FG*a + BG*(255-a)) / 255 (five ALU cycles).
//             Commands enter on a valid/ready handshake; the registered result
//             leaves on a valid/ready handshake.
//  Ports    : clk_i, rst_ni            clock, asynchronous active-low reset
//             in_valid_i/in_ready_o    command handshake
//             in_blend_i, in_sel_i     command type / single-op ALU select
//             in_a_i, in_b_i           operand A / B (FG / BG for a blend)
//             in_alpha_i               per-lane alpha (blend only)
//             alu_a_o, alu_b_o,
//             alu_sel_o, alu_c_i       shared ALU operands, select and result
//             out_valid_o/out_ready_i  result handshake
//             out_data_o               registered result
//             busy_o                   sequencer not idle
//  Revision : 1.0 - initial release
// ============================================================================
module alpha_blend_sequencer #(
    parameter int N    = 128,
    parameter int LANE = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         in_blend_i,
    input  logic [2:0]   in_sel_i,
    input  logic [N-1:0] in_a_i,
    input  logic [N-1:0] in_b_i,
    input  logic [N-1:0] in_alpha_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [2:0]   alu_sel_o,
    input  logic [N-1:0] alu_c_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_data_o,
    output logic         busy_o
);

    localparam logic [2:0] C_SEL_ADD = 3'd2;
    localparam logic [2:0] C_SEL_SUB = 3'd3;
    localparam logic [2:0] C_SEL_MUL = 3'd4;
    localparam logic [2:0] C_SEL_DIV = 3'd5;

    // Every lane holds 255: the alpha complement minuend and the divisor.
    localparam logic [LANE-1:0] C_LANE_MAX = LANE'(255);
    localparam logic [N-1:0]    C_MAX      = {(N/LANE){C_LANE_MAX}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_SUB  = 3'd2,
        S_MULF = 3'd3,
        S_MULB = 3'd4,
        S_ADD  = 3'd5,
        S_DIV  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, b_q, alpha_q;
    logic [2:0]     sel_q;
    logic [N-1:0]   t0_q, t1_q, t2_q;
    logic [N-1:0]   out_q;

    // ALU drive and next state. The ALU is combinational, so each compute
    // state presents its operands here and the result is captured at the
    // closing edge in the sequential block below.
    always_comb begin
        state_d   = state_q;
        alu_a_o   = '0;
        alu_b_o   = '0;
        alu_sel_o = 3'd0;
        case (state_q)
            S_IDLE: if (in_valid_i) state_d = in_blend_i ? S_SUB : S_EXEC;
            S_EXEC: begin
                alu_a_o = a_q;   alu_b_o = b_q;     alu_sel_o = sel_q;
                state_d = S_DONE;
            end
            S_SUB: begin
                alu_a_o = C_MAX; alu_b_o = alpha_q; alu_sel_o = C_SEL_SUB;
                state_d = S_MULF;
            end
            S_MULF: begin
                alu_a_o = a_q;   alu_b_o = alpha_q; alu_sel_o = C_SEL_MUL;
                state_d = S_MULB;
            end
            S_MULB: begin
                alu_a_o = b_q;   alu_b_o = t0_q;    alu_sel_o = C_SEL_MUL;
                state_d = S_ADD;
            end
            S_ADD: begin
                alu_a_o = t1_q;  alu_b_o = t2_q;    alu_sel_o = C_SEL_ADD;
                state_d = S_DIV;
            end
            S_DIV: begin
                alu_a_o = t1_q;  alu_b_o = C_MAX;   alu_sel_o = C_SEL_DIV;
                state_d = S_DONE;
            end
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            alpha_q <= '0;
            sel_q   <= 3'd0;
            t0_q    <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (in_valid_i) begin
                    a_q     <= in_a_i;
                    b_q     <= in_b_i;
                    alpha_q <= in_alpha_i;
                    sel_q   <= in_sel_i;
                end
                S_EXEC: out_q <= alu_c_i;
                S_SUB:  t0_q  <= alu_c_i;
                S_MULF: t1_q  <= alu_c_i;
                S_MULB: t2_q  <= alu_c_i;
                S_ADD:  t1_q  <= alu_c_i;    // FG*a + BG*(255-a) reuses T1
                S_DIV:  out_q <= alu_c_i;
                default: ;
            endcase
        end
    end

    // Handshake flags are decoded straight from the state register, so they
    // are glitch-free and change only on a clock edge or on reset.
    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign out_data_o  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_alpha_blend_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alpha_blend_sequencer
//  Purpose  : Self-checking bench for alpha_blend_sequencer. Provides a
//             behavioural vector ALU, directed scenarios and randomized
//             commands checked against a per-lane arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alpha_blend_sequencer;

    localparam int N     = 128;
    localparam int LANE  = 16;
    localparam int LANES = N / LANE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_blend = 1'b0;
    logic [2:0]   in_sel = 3'd0;
    logic [N-1:0] in_a = '0, in_b = '0, in_alpha = '0;
    logic [N-1:0] alu_a, alu_b, alu_c;
    logic [2:0]   alu_sel;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Per-command observations collected by run_cmd
    int           lat;
    logic [2:0]   sel_log [8];
    logic [N-1:0] a_log   [8];
    logic [N-1:0] b_log   [8];
    logic [N-1:0] res;

    always #5 clk = ~clk;

    alpha_blend_sequencer #(.N(N), .LANE(LANE)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_blend_i  (in_blend),
        .in_sel_i    (in_sel),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_alpha_i  (in_alpha),
        .alu_a_o     (alu_a),
        .alu_b_o     (alu_b),
        .alu_sel_o   (alu_sel),
        .alu_c_i     (alu_c),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy)
    );

    // One ALU lane: 16-bit wrap-around; divide by zero returns all ones.
    function automatic logic [15:0] lane_op(input logic [2:0] s, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] r;
        case (s)
            3'd1: r = {16'd0, x};
            3'd2: r = 32'(x) + 32'(y);
            3'd3: r = 32'(x) - 32'(y);
            3'd4: r = 32'(x) * 32'(y);
            3'd5: r = (y == 16'd0) ? 32'hFFFF : 32'(x / y);
            default: r = 32'd0;
        endcase
        return r[15:0];
    endfunction

    always_comb begin
        alu_c = '0;
        for (int i = 0; i < LANES; i++)
            alu_c[i*LANE +: LANE] = lane_op(alu_sel, alu_a[i*LANE +: LANE], alu_b[i*LANE +: LANE]);
    end

    function automatic logic [N-1:0] rep(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [N-1:0] model_single(input logic [2:0] s, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*LANE +: LANE] = lane_op(s, a[i*LANE +: LANE], b[i*LANE +: LANE]);
        return r;
    endfunction

    // Alpha composite straight from the formula, in plain integer arithmetic.
    function automatic logic [N-1:0] model_blend(input logic [N-1:0] fg, input logic [N-1:0] bg, input logic [N-1:0] al);
        logic [N-1:0] r = '0;
        int f, g, a, v;
        for (int i = 0; i < LANES; i++) begin
            f = int'(fg[i*LANE +: LANE]);
            g = int'(bg[i*LANE +: LANE]);
            a = int'(al[i*LANE +: LANE]);
            v = (f * a + g * (255 - a)) / 255;
            r[i*LANE +: LANE] = v[15:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one command, log ALU activity until out_valid, hold the result
    // under backpressure for 'hold' cycles, then complete the handshake while
    // a junk command is presented (it must not be accepted).
    task automatic run_cmd(input logic blend, input logic [2:0] sel, input logic [N-1:0] a,
                           input logic [N-1:0] b, input logic [N-1:0] al, input int hold);
        @(negedge clk);
        in_valid = 1'b1; in_blend = blend; in_sel = sel;
        in_a = a; in_b = b; in_alpha = al;
        chk("accept_ready", N'(in_ready), N'(1));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 8) begin
                sel_log[lat] = alu_sel; a_log[lat] = alu_a; b_log[lat] = alu_b;
            end
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("timeout_out_valid", N'(out_valid), N'(1));
        res = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_a = {4{$urandom}};
            @(negedge clk);
            chk("hold_valid", N'(out_valid), N'(1));
            chk("hold_data", out_data, res);
            chk("hold_in_ready", N'(in_ready), N'(0));
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ret_idle", N'({busy, in_ready, out_valid}), N'(3'b010));
        in_valid = 1'b0;
    endtask

    initial begin
        logic [N-1:0] va, vb, val, exp;
        logic         bl;
        logic [2:0]   sl;

        // Reset state
        #12;
        chk("rst_out_valid", N'(out_valid), N'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_alu_sel", N'(alu_sel), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", N'(in_ready), N'(1));

        // Single add
        run_cmd(1'b0, 3'd2, rep(16'd3), rep(16'd4), rep(16'd77), 0);
        chk("add_data", res, rep(16'd7));
        chk("add_lat", N'(lat), N'(1));
        chk("add_sel", N'(sel_log[0]), N'(2));

        // Blend, mid alpha, with intermediate values visible on the ALU ports
        run_cmd(1'b1, 3'd0, rep(16'd200), rep(16'd100), rep(16'd128), 0);
        chk("mid_data", res, rep(16'd150));
        chk("mid_lat", N'(lat), N'(5));
        chk("mid_sels", N'({sel_log[0], sel_log[1], sel_log[2], sel_log[3], sel_log[4]}),
            N'({3'd3, 3'd4, 3'd4, 3'd2, 3'd5}));
        chk("mid_t0", b_log[2], rep(16'd127));
        chk("mid_t1", a_log[3], rep(16'd25600));
        chk("mid_t2", b_log[3], rep(16'd12700));
        chk("mid_sum", a_log[4], rep(16'd38300));
        chk("mid_div", b_log[4], rep(16'd255));

        // Endpoints and lane independence
        run_cmd(1'b1, 3'd0, rep(16'd200), rep(16'd100), rep(16'd255), 0);
        chk("alpha255", res, rep(16'd200));
        run_cmd(1'b1, 3'd0, rep(16'd200), rep(16'd100), rep(16'd0), 0);
        chk("alpha0", res, rep(16'd100));
        val = rep(16'd128);
        val[15:0] = 16'd0; val[31:16] = 16'd255;
        run_cmd(1'b1, 3'd0, rep(16'd200), rep(16'd100), val, 0);
        chk("mixed_lanes", res, model_blend(rep(16'd200), rep(16'd100), val));
        chk("mixed_lane01", N'(res[31:0]), N'({16'd200, 16'd100}));

        // Backpressure for 10 cycles after a blend
        run_cmd(1'b1, 3'd0, rep(16'd50), rep(16'd250), rep(16'd30), 10);
        chk("bp_data", res, model_blend(rep(16'd50), rep(16'd250), rep(16'd30)));

        // Reset while in MULB
        @(negedge clk);
        in_valid = 1'b1; in_blend = 1'b1;
        in_a = rep(16'd200); in_b = rep(16'd100); in_alpha = rep(16'd128);
        @(negedge clk); in_valid = 1'b0;   // SUB
        @(negedge clk);                    // MULF
        @(negedge clk);                    // MULB
        chk("mulb_sel", N'(alu_sel), N'(4));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", N'(out_valid), N'(0));
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_sel", N'(alu_sel), N'(0));
        chk("mid_rst_busy", N'(busy), N'(0));
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", N'(in_ready), N'(1));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", N'(out_valid), N'(0));
        end
        run_cmd(1'b0, 3'd1, rep(16'd9), rep(16'd5), '0, 0);
        chk("post_rst_pass", res, rep(16'd9));

        // Single ops that return zero
        run_cmd(1'b0, 3'd7, rep(16'd9), rep(16'd5), '0, 0);
        chk("sel7_zero", res, '0);

        // Randomized commands against the reference model
        for (int n = 0; n < 24; n++) begin
            bl = 1'($urandom_range(0, 1));
            sl = 3'($urandom_range(0, 7));
            for (int i = 0; i < LANES; i++) begin
                if (bl) begin
                    va[i*LANE +: LANE]  = 16'($urandom_range(0, 255));
                    vb[i*LANE +: LANE]  = 16'($urandom_range(0, 255));
                    val[i*LANE +: LANE] = 16'($urandom_range(0, 255));
                end else begin
                    va[i*LANE +: LANE]  = 16'($urandom);
                    vb[i*LANE +: LANE]  = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
                    val[i*LANE +: LANE] = 16'($urandom);
                end
            end
            run_cmd(bl, sl, va, vb, val, int'($urandom_range(0, 3)));
            exp = bl ? model_blend(va, vb, val) : model_single(sl, va, vb);
            chk(bl ? "rand_blend" : "rand_single", res, exp);
            chk("rand_lat", N'(lat), N'(bl ? 5 : 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alpha_blend_sequencer.md
# alpha_blend_sequencer

Controller that sequences the shared vectorial ALU (128-bit, eight 16-bit lanes; Sel codes 0 zero, 1 pass A, 2 add, 3 sub, 4 mul, 5 div, 6/7 zero) to run either a single vector operation or a full per-lane alpha composite, out = (FG·α + BG·(255−α)) / 255. It sits between the pixel-fetch stage and the write-back stage. It accepts one command per valid/ready handshake, drives the ALU operand and select ports over one or five cycles, holds intermediates in internal registers, and presents the registered result under a valid/ready handshake.

## Interface
- N, 128, vector width in bits; must be a multiple of LANE
- LANE, 16, lane width in bits; pixel and alpha values are 8-bit, zero-extended into each lane
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  sequencer can accept a command
- in_blend  input  1  1 = alpha composite, 0 = single op
- in_sel  input  3  ALU select for a single op; ignored when in_blend=1
- in_a  input  N  single op: operand A; blend: FG
- in_b  input  N  single op: operand B; blend: BG
- in_alpha  input  N  per-lane alpha, 0..255; used only when in_blend=1
- alu_a, alu_b  output  N  ALU operands
- alu_sel  output  3  ALU select
- alu_c  input  N  combinational ALU result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  N  registered result
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, SUB, MULF, MULB, ADD, DIV, DONE.
- IDLE: in_ready=1. On in_valid, latch in_a, in_b, in_alpha, in_sel and in_blend. Next state is SUB if in_blend=1, otherwise EXEC.
- MAX is a constant vector with every lane = 255.
- Each compute state drives alu_a, alu_b and alu_sel combinationally and captures alu_c at the closing clock edge:
  - EXEC: (A, B, in_sel) → out_data; then DONE
  - SUB: (MAX, α, 3) → T0; then MULF
  - MULF: (FG, α, 4) → T1; then MULB
  - MULB: (BG, T0, 4) → T2; then ADD
  - ADD: (T1, T2, 2) → T1; then DIV
  - DIV: (T1, MAX, 5) → out_data; then DONE
- DONE: out_valid=1 and out_data is held stable. When out_ready=1, return to IDLE.
- In IDLE and DONE the ALU ports are idle: alu_a=0, alu_b=0, alu_sel=0.
- Width rules:
  - 255·255 = 65025 fits in 16 bits, so with valid 8-bit inputs no intermediate overflows.
  - Lanes are never mixed.
  - Out-of-range inputs, division results and wrap-around behaviour are defined by the ALU; the sequencer passes them through unmodified.
- A single op with in_sel 0, 6 or 7 still executes and returns 0.
- The sequencer does not check for division by zero.
- in_ready is 0 in every state except IDLE. A command cannot be accepted in the same cycle a result is consumed.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; out_valid=0; out_data=0; T0, T1, T2 and latched operands = 0; alu_sel=0; busy=0
  - in_ready=1 once rst is released; in_valid is ignored while rst=0
- Accept at edge E0:
  - single op: out_valid rises after E1, latency 1
  - blend: SUB..DIV occupy cycles E0→E5, out_valid rises after E5, latency 5
- The earliest next accept is one cycle after the out_valid/out_ready handshake. Minimum initiation interval is 3 cycles for single ops and 7 cycles for blends.
- Backpressure: out_valid stays high and out_data stays constant for any number of cycles with out_ready=0.
- Reset mid-operation abandons the command: no out_valid pulse, all state cleared immediately.
- Simultaneous in_valid with the DONE handshake: the command is not accepted and must be held until the next cycle.

## Test plan
- Reset: assert rst=0 mid-stream → out_valid=0, out_data=0, alu_sel=0, busy=0 immediately; after release, in_ready=1.
- Single add: in_blend=0, in_sel=2, A=all lanes 3, B=all lanes 4 → out_valid one cycle after accept, out_data=all lanes 7; alu_sel=2 during EXEC.
- Blend mid alpha: FG=200, BG=100, α=128 → alu_sel sequence 3,4,4,2,5; T0=127, T1=25600, T2=12700, sum 38300; out_data=150 in every lane, 5 cycles after accept.
- Blend endpoints: α=255 → 200; α=0 → 100. Mixed lanes, lane0 α=0 and lane1 α=255 → lane0=100, lane1=200, showing lane independence.
- Backpressure: out_ready=0 for 10 cycles after a blend → out_data stable, in_ready=0 and in_valid ignored throughout; the handshake then returns to IDLE.
- Reset in MULB during a blend → no out_valid. A new single op (sel=1, A=all 9) then returns all lanes 9 with no stale temporaries.
